// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer: one-sector byte buffer between the host and the SD card
// controller. Launches controller read/write commands, streams bytes to or
// from the buffer, and reports completion, length errors and watchdog timeouts.

module sd_sector_buffer #(
   parameter int SECTOR_BYTES   = 512,
   parameter int TIMEOUT_CYCLES = 16777215
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        req_write,
   input  logic [25:0] req_sector,
   input  logic        host_wr_en,
   input  logic [8:0]  host_addr,
   input  logic [7:0]  host_wr_data,
   output logic [7:0]  host_rd_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        err_timeout,
   output logic        ctrl_execute,
   output logic        ctrl_op_code,
   output logic [25:0] ctrl_sector_address,
   output logic [7:0]  ctrl_outgoing_byte,
   input  logic [7:0]  ctrl_incoming_byte,
   input  logic        ctrl_finished_byte,
   input  logic        ctrl_finished_sector,
   input  logic        ctrl_busy
);

   localparam int CNT_W = $clog2(SECTOR_BYTES) + 1;
   localparam int AW    = CNT_W - 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SECTOR_BYTES);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_XFER   = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   logic [7:0]       mem [SECTOR_BYTES];

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             op_q, op_d;
   logic [25:0]      sect_q, sect_d;
   logic             err_q, err_d;
   logic             tmo_q, tmo_d;
   logic             fb_q, fb_p_q, fs_q, fs_p_q;
   logic [7:0]       host_rd_q, out_q;

   logic             byte_evt, sect_evt, busy_w;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [7:0]       mem_wdata;

   assign byte_evt = fb_q & ~fb_p_q;
   assign sect_evt = fs_q & ~fs_p_q;
   assign busy_w   = (state_q == S_WAIT) || (state_q == S_LAUNCH) || (state_q == S_XFER);

   assign busy                = busy_w;
   assign done                = (state_q == S_FINISH);
   assign err                 = err_q;
   assign err_timeout         = tmo_q;
   assign ctrl_execute        = (state_q == S_LAUNCH);
   assign ctrl_op_code        = op_q;
   assign ctrl_sector_address = sect_q;
   assign ctrl_outgoing_byte  = out_q;
   assign host_rd_data        = host_rd_q;

   // Next-state, byte accounting, watchdog and buffer write-port selection
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      op_d      = op_q;
      sect_d    = sect_q;
      err_d     = 1'b0;
      tmo_d     = 1'b0;
      wd_d      = '0;
      mem_we    = 1'b0;
      mem_waddr = host_addr;
      mem_wdata = host_wr_data;

      if (host_wr_en && !busy_w) begin
         mem_we = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (req) begin
               op_d    = req_write;
               sect_d  = req_sector;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!ctrl_busy) begin
               state_d = S_LAUNCH;
            end else if (wd_q == WD_LAST) begin
               state_d = S_FINISH;
               err_d   = 1'b1;
               tmo_d   = 1'b1;
            end
         end
         S_LAUNCH: begin
            state_d = S_XFER;
         end
         S_XFER: begin
            if (byte_evt) begin
               if (cnt_q != CNT_FULL) begin
                  cnt_d = cnt_q + 1'b1;
                  if (!op_q) begin
                     mem_we    = 1'b1;
                     mem_waddr = cnt_q[AW-1:0];
                     mem_wdata = ctrl_incoming_byte;
                  end
               end else begin
                  ovf_d = 1'b1;
               end
            end
            // byte event (if any) is already folded into cnt_d/ovf_d here
            if (sect_evt) begin
               state_d = S_FINISH;
               err_d   = (cnt_d != CNT_FULL) | ovf_d;
            end else if (!byte_evt && wd_q == WD_LAST) begin
               state_d = S_FINISH;
               err_d   = 1'b1;
               tmo_d   = 1'b1;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == state_q && !byte_evt &&
          (state_q == S_WAIT || state_q == S_XFER)) begin
         wd_d = wd_q + 1'b1;
      end
   end

   // Control registers, edge-detect samplers and registered read ports
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         wd_q      <= '0;
         op_q      <= 1'b0;
         sect_q    <= '0;
         err_q     <= 1'b0;
         tmo_q     <= 1'b0;
         fb_q      <= 1'b0;
         fb_p_q    <= 1'b0;
         fs_q      <= 1'b0;
         fs_p_q    <= 1'b0;
         host_rd_q <= '0;
         out_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         wd_q      <= wd_d;
         op_q      <= op_d;
         sect_q    <= sect_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
         fb_q      <= ctrl_finished_byte;
         fb_p_q    <= fb_q;
         fs_q      <= ctrl_finished_sector;
         fs_p_q    <= fs_q;
         host_rd_q <= mem[host_addr];
         out_q     <= mem[cnt_d[AW-1:0]];
      end
   end

   // Sector RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

endmodule
